// File: rtl/ram_program_loader.sv
// Program loader: streams bytes into the program RAM, optionally reads them back
// to verify the checksum, and holds the CPU in reset until a load has passed.
module ram_program_loader #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int WE_CYC    = 1,
  parameter int RD_LAT    = 1,
  parameter int VERIFY_EN = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_ce,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    IDLE, CHECK, LOAD, WRITE, RD_ISSUE, RD_WAIT, DONE, ERROR
  } state_t;

  localparam logic [ADDR_W+1:0] DEPTH   = (ADDR_W+2)'(2**ADDR_W);
  localparam logic [7:0]        WE_LAST = 8'(WE_CYC - 1);
  localparam logic [7:0]        RD_LAST = 8'(RD_LAT - 1);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] base_q, ptr;
  logic [ADDR_W:0]   len_q, cnt, cnt_inc;
  logic [DATA_W-1:0] rsum, rsum_nx;
  logic [7:0]        cyc;
  logic [ADDR_W+1:0] end_addr;
  logic              start_go, take, wr_last, rd_last, last_word;

  function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    return a + b;
  endfunction

  // Widened so base+length cannot overflow before the range check.
  assign end_addr  = (ADDR_W+2)'(base_q) + (ADDR_W+2)'(len_q);
  assign cnt_inc   = cnt + (ADDR_W+1)'(1);
  assign last_word = (cnt_inc == len_q);
  assign rsum_nx   = csum_add(rsum, ram_rdata);
  assign ram_addr  = ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    ram_we   = 1'b0;
    ram_ce   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    err      = 1'b0;
    cpu_hold = 1'b1;
    start_go = 1'b0;
    take     = 1'b0;
    wr_last  = 1'b0;
    rd_last  = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_go = 1'b1;
          state_nx = CHECK;
        end
      end
      CHECK: begin
        if (len_q == '0 || end_addr > DEPTH) state_nx = ERROR;
        else                                 state_nx = LOAD;
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          take     = 1'b1;
          state_nx = WRITE;
        end
      end
      WRITE: begin
        ram_we = 1'b1;
        if (cyc == WE_LAST) begin
          wr_last = 1'b1;
          if (last_word) state_nx = (VERIFY_EN != 0) ? RD_ISSUE : DONE;
          else           state_nx = LOAD;
        end
      end
      RD_ISSUE, RD_WAIT: begin
        ram_ce = 1'b1;
        if (cyc == RD_LAST) begin
          rd_last = 1'b1;
          // rsum_nx already includes the word being sampled this cycle.
          if (last_word) state_nx = (rsum_nx == checksum) ? DONE : ERROR;
          else           state_nx = RD_ISSUE;
        end else begin
          state_nx = RD_WAIT;
        end
      end
      DONE: begin
        busy     = 1'b0;
        cpu_hold = 1'b0;
        done     = 1'b1;
        if (start) begin
          start_go = 1'b1;
          state_nx = CHECK;
        end
      end
      ERROR: begin
        busy = 1'b0;
        err  = 1'b1;
        if (start) begin
          start_go = 1'b1;
          state_nx = CHECK;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q    <= '0;
      len_q     <= '0;
      ptr       <= '0;
      cnt       <= '0;
      cyc       <= '0;
      ram_wdata <= '0;
      checksum  <= '0;
      rsum      <= '0;
    end else begin
      if (start_go) begin
        base_q   <= base_addr;
        len_q    <= length;
        ptr      <= base_addr;
        cnt      <= '0;
        checksum <= '0;
        rsum     <= '0;
      end
      if (take) begin
        ram_wdata <= in_data;
        checksum  <= csum_add(checksum, in_data);
      end
      if (wr_last || rd_last || state_nx != state) cyc <= '0;
      else if (ram_we || ram_ce)                   cyc <= cyc + 8'd1;
      // Rewind to base after the last write so read-back starts at the block head.
      if (wr_last) begin
        if (last_word) begin
          ptr <= base_q;
          cnt <= '0;
        end else begin
          ptr <= ptr + ADDR_W'(1);
          cnt <= cnt_inc;
        end
      end
      if (rd_last) begin
        rsum <= rsum_nx;
        ptr  <= ptr + ADDR_W'(1);
        cnt  <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_ram_program_loader.sv
// Directed bench for ram_program_loader with a behavioural 16x8 RAM that can
// corrupt bit 0 of address 2 on read-back.
module tb_ram_program_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] base_addr = '0;
  logic [4:0] length = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       ram_ce;
  logic [7:0] ram_rdata;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] checksum;

  logic       flip = 1'b0;
  logic [7:0] mem [16];
  logic [3:0] wr_log [256];
  int         wr_cnt = 0;
  int         ce_cnt = 0;
  int         overlap_cnt = 0;
  int         checks = 0;
  int         errors = 0;

  ram_program_loader #(
    .ADDR_W(4), .DATA_W(8), .WE_CYC(1), .RD_LAT(1), .VERIFY_EN(1)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .length(length), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_ce(ram_ce), .ram_rdata(ram_rdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr] ^ {7'b0, (flip && ram_addr == 4'd2)};

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]  <= ram_wdata;
      wr_log[wr_cnt] <= ram_addr;
      wr_cnt         <= wr_cnt + 1;
    end
    if (ram_ce) ce_cnt <= ce_cnt + 1;
    if (ram_we && ram_ce) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [3:0] b, input logic [4:0] l);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input int gap);
    int n;
    repeat (gap) tick();
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("send_timeout", (n < 50), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 500) begin
      tick();
      n++;
    end
    chk("busy_timeout", (n < 500), 1);
  endtask

  initial begin
    int         wb;
    int         cb;
    int         bad;
    logic [7:0] d;
    logic [7:0] exp_sum;

    // Reset values
    #2 reset = 1'b1;
    tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_we_ce", {ram_we, ram_ce}, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_wdata", ram_wdata, 0);
    chk("rst_cpu_hold", cpu_hold, 1);
    chk("rst_busy_done_err", {busy, done, err}, 0);
    chk("rst_checksum", checksum, 0);

    // Basic load of four bytes with read-back; in_valid alongside start is ignored
    wb = wr_cnt;
    cb = ce_cnt;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    pulse_start(4'd0, 5'd4);
    in_valid = 1'b0;
    chk("t2_start_no_take", {in_ready, checksum}, 0);
    chk("t2_busy", busy, 1);
    send_byte(8'h09, 0);
    send_byte(8'h1A, 0);
    send_byte(8'h2B, 0);
    send_byte(8'hE0, 0);
    wait_idle();
    chk("t2_writes", wr_cnt - wb, 4);
    for (int i = 0; i < 4; i++) chk("t2_addr", wr_log[wb+i], i);
    chk("t2_reads", ce_cnt - cb, 4);
    chk("t2_checksum", checksum, 8'h2E);
    chk("t2_done", done, 1);
    chk("t2_err", err, 0);
    chk("t2_cpu_hold", cpu_hold, 0);

    // Full 16-byte load with random valid gaps
    wb = wr_cnt;
    exp_sum = 8'h00;
    pulse_start(4'd0, 5'd16);
    for (int i = 0; i < 16; i++) begin
      d = 8'(i * 37 + 5);
      exp_sum = exp_sum + d;
      send_byte(d, int'($urandom_range(0, 3)));
    end
    wait_idle();
    chk("t3_writes", wr_cnt - wb, 16);
    bad = 0;
    for (int i = 0; i < 16; i++) if (wr_log[wb+i] !== 4'(i)) bad++;
    chk("t3_addr_seq", bad, 0);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[i] !== 8'(i * 37 + 5)) bad++;
    chk("t3_mem", bad, 0);
    chk("t3_checksum", checksum, exp_sum);
    chk("t3_done", {done, err}, 2'b10);
    chk("t3_we_ce_overlap", overlap_cnt, 0);

    // Range errors: block past end of RAM, then zero length
    wb = wr_cnt;
    pulse_start(4'hD, 5'd4);
    chk("t4_check_busy", busy, 1);
    tick();
    chk("t4_err", err, 1);
    chk("t4_cpu_hold", cpu_hold, 1);
    chk("t4_done", done, 0);
    repeat (3) tick();
    pulse_start(4'd0, 5'd0);
    chk("t4_err_cleared", err, 0);
    tick();
    chk("t4_len0_err", {err, done, cpu_hold}, 3'b101);
    chk("t4_no_writes", wr_cnt - wb, 0);

    // Block ending exactly at the top of RAM is legal
    wb = wr_cnt;
    pulse_start(4'hC, 5'd4);
    send_byte(8'h01, 0);
    send_byte(8'h02, 1);
    send_byte(8'h03, 0);
    send_byte(8'h04, 2);
    wait_idle();
    chk("t4_top_done", {done, err}, 2'b10);
    chk("t4_top_first", wr_log[wb], 4'hC);
    chk("t4_top_last", wr_log[wb+3], 4'hF);
    chk("t4_top_checksum", checksum, 8'h0A);

    // Corrupted read-back at address 2
    flip = 1'b1;
    pulse_start(4'd0, 5'd4);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    send_byte(8'h33, 0);
    send_byte(8'h44, 0);
    wait_idle();
    chk("t5_err", err, 1);
    chk("t5_done", done, 0);
    chk("t5_cpu_hold", cpu_hold, 1);
    chk("t5_checksum", checksum, 8'hAA);
    flip = 1'b0;

    // start during LOAD is ignored
    wb = wr_cnt;
    pulse_start(4'd0, 5'd2);
    tick();
    pulse_start(4'd5, 5'd9);
    chk("t6_still_load", {in_ready, busy}, 2'b11);
    send_byte(8'h5A, 0);
    send_byte(8'hA5, 0);
    wait_idle();
    chk("t6_done", done, 1);
    chk("t6_writes", wr_cnt - wb, 2);
    chk("t6_addr", {wr_log[wb], wr_log[wb+1]}, 8'h01);
    chk("t6_checksum", checksum, 8'hFF);

    // start from DONE drops done and raises cpu_hold on the same edge
    pulse_start(4'd0, 5'd3);
    chk("t6_restart_done", done, 0);
    chk("t6_restart_hold", cpu_hold, 1);
    chk("t6_restart_busy", busy, 1);
    send_byte(8'h77, 0);
    tick();
    chk("t6_in_load", in_ready, 1);

    // Asynchronous reset in the middle of a load
    reset = 1'b0;
    #1;
    chk("t1_midrst_busy", busy, 0);
    chk("t1_midrst_ready", in_ready, 0);
    chk("t1_midrst_hold", cpu_hold, 1);
    chk("t1_midrst_flags", {done, err, ram_we, ram_ce}, 0);
    chk("t1_midrst_addr_data", {ram_addr, ram_wdata}, 0);
    chk("t1_midrst_checksum", checksum, 0);
    reset = 1'b1;
    tick();
    chk("t1_after_rst_idle", {busy, in_ready, cpu_hold}, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
